// File: rtl/player_controller.sv
// player_controller
//   Owns the player's position and view angle. On each `start` pulse it
//   applies one frame of button input: the angle turns immediately, then the
//   x and y moves are each checked against the level grid. Each axis takes
//   three cycles: drive the address, wait for the registered read, then check
//   the cell. Both reads are performed even when an axis does not move, so
//   every update takes the same 8 cycles.
//
// Ports
//   clock, reset         system clock; synchronous active-high reset
//   reset_player         load spawn position/angle, abort any update
//   start / done         begin a frame update / one-cycle completion pulse
//   key_*                move (world axes) and turn buttons, active-high
//   grid_x, grid_y       grid read address (0 outside the check phases)
//   grid_out             registered grid cell contents, 0 = empty
//   player_x/_y/_angle   8.8 fixed-point position and 8-bit angle
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; grid address parked at 0
// X_REQ   | drive address of candidate x cell
// X_WAIT  | grid read in flight
// X_CHECK | commit candidate x if the cell is empty
// Y_REQ   | drive address of candidate y cell (uses committed x)
// Y_WAIT  | grid read in flight
// Y_CHECK | commit candidate y if the cell is empty
// DONE    | done pulse, back to IDLE
module player_controller #(
  parameter int unsigned SPEED       = 16,
  parameter logic [7:0]  TURN_STEP   = 8'd2,
  parameter logic [13:0] SPAWN_X     = 14'd384,
  parameter logic [12:0] SPAWN_Y     = 13'd384,
  parameter logic [7:0]  SPAWN_ANGLE = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reset_player,
  input  logic        start,
  output logic        done,
  input  logic        key_north,
  input  logic        key_south,
  input  logic        key_east,
  input  logic        key_west,
  input  logic        key_turn_left,
  input  logic        key_turn_right,
  output logic [5:0]  grid_x,
  output logic [4:0]  grid_y,
  input  logic [2:0]  grid_out,
  output logic [13:0] player_x,
  output logic [12:0] player_y,
  output logic [7:0]  player_angle
);

  typedef enum logic [2:0] {
    IDLE, X_REQ, X_WAIT, X_CHECK, Y_REQ, Y_WAIT, Y_CHECK, DONE
  } state_t;

  localparam logic [13:0] STEP_X = 14'(SPEED);
  localparam logic [12:0] STEP_Y = 13'(SPEED);

  state_t state_q, state_d;

  logic key_north_q, key_south_q, key_east_q, key_west_q;

  logic [14:0] sum_x;
  logic [13:0] sum_y;
  logic [13:0] cand_x;
  logic [12:0] cand_y;
  logic [7:0]  angle_next;

  // Candidates come from the latched keys and the current position. player_y
  // does not change until Y_CHECK, so cand_y is stable through the Y phase.
  // The extra top bit of each sum flags overflow past the coordinate range.
  always_comb begin
    sum_x  = {1'b0, player_x} + {1'b0, STEP_X};
    sum_y  = {1'b0, player_y} + {1'b0, STEP_Y};
    cand_x = player_x;
    cand_y = player_y;
    if (key_east_q && !key_west_q) begin
      if (!sum_x[14]) cand_x = sum_x[13:0];
    end else if (key_west_q && !key_east_q) begin
      if (player_x >= STEP_X) cand_x = player_x - STEP_X;
    end
    if (key_south_q && !key_north_q) begin
      if (!sum_y[13]) cand_y = sum_y[12:0];
    end else if (key_north_q && !key_south_q) begin
      if (player_y >= STEP_Y) cand_y = player_y - STEP_Y;
    end
  end

  always_comb begin
    angle_next = player_angle;
    case ({key_turn_left, key_turn_right})
      2'b10:   angle_next = player_angle - TURN_STEP;
      2'b01:   angle_next = player_angle + TURN_STEP;
      default: angle_next = player_angle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grid_x  = 6'd0;
    grid_y  = 5'd0;
    case (state_q)
      IDLE:    if (start) state_d = X_REQ;
      X_REQ:   state_d = X_WAIT;
      X_WAIT:  state_d = X_CHECK;
      X_CHECK: state_d = Y_REQ;
      Y_REQ:   state_d = Y_WAIT;
      Y_WAIT:  state_d = Y_CHECK;
      Y_CHECK: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset_player) state_d = IDLE;

    case (state_q)
      X_REQ, X_WAIT, X_CHECK: begin
        grid_x = cand_x[13:8];
        grid_y = player_y[12:8];
      end
      // player_x already holds the x result here, giving wall sliding.
      Y_REQ, Y_WAIT, Y_CHECK: begin
        grid_x = player_x[13:8];
        grid_y = cand_y[12:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      player_x     <= '0;
      player_y     <= '0;
      player_angle <= '0;
      done         <= 1'b0;
      key_north_q  <= 1'b0;
      key_south_q  <= 1'b0;
      key_east_q   <= 1'b0;
      key_west_q   <= 1'b0;
    end else if (reset_player) begin
      player_x     <= SPAWN_X;
      player_y     <= SPAWN_Y;
      player_angle <= SPAWN_ANGLE;
      done         <= 1'b0;
    end else begin
      done <= (state_q == Y_CHECK);
      case (state_q)
        IDLE: begin
          if (start) begin
            key_north_q  <= key_north;
            key_south_q  <= key_south;
            key_east_q   <= key_east;
            key_west_q   <= key_west;
            player_angle <= angle_next;
          end
        end
        X_CHECK: if (grid_out == 3'd0) player_x <= cand_x;
        Y_CHECK: if (grid_out == 3'd0) player_y <= cand_y;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_controller.sv
module tb_player_controller;

  localparam int SPEED   = 16;
  localparam int TURN    = 2;
  localparam int SPAWN_X = 384;
  localparam int SPAWN_Y = 384;
  localparam int SPAWN_A = 0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reset_player = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic        key_north = 1'b0, key_south = 1'b0, key_east = 1'b0, key_west = 1'b0;
  logic        key_turn_left = 1'b0, key_turn_right = 1'b0;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic [2:0]  grid_out;
  logic [13:0] player_x;
  logic [12:0] player_y;
  logic [7:0]  player_angle;

  logic [2:0] grid [0:31][0:63];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_x, m_y, m_a;

  typedef struct {
    int x;
    int y;
    int a;
    int edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  player_controller #(
    .SPEED(SPEED), .TURN_STEP(8'(TURN)), .SPAWN_X(14'(SPAWN_X)),
    .SPAWN_Y(13'(SPAWN_Y)), .SPAWN_ANGLE(8'(SPAWN_A))
  ) dut (
    .clock(clock), .reset(reset), .reset_player(reset_player), .start(start),
    .done(done), .key_north(key_north), .key_south(key_south),
    .key_east(key_east), .key_west(key_west), .key_turn_left(key_turn_left),
    .key_turn_right(key_turn_right), .grid_x(grid_x), .grid_y(grid_y),
    .grid_out(grid_out), .player_x(player_x), .player_y(player_y),
    .player_angle(player_angle)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    grid_out <= grid[grid_y][grid_x];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding update.
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no update outstanding at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", cyc - mon_e.edge_n + 1, 7);
        chk("player_x", int'(player_x), mon_e.x);
        chk("player_y", int'(player_y), mon_e.y);
        chk("player_angle", int'(player_angle), mon_e.a);
      end
    end
  end

  // Reference: one frame from the rules, in plain integer arithmetic.
  function automatic void model(input logic [5:0] k, output int cx, output int cy,
                                output int nx, output int ny, output int na);
    int n = int'(k[5]);
    int s = int'(k[4]);
    int e = int'(k[3]);
    int w = int'(k[2]);
    int l = int'(k[1]);
    int r = int'(k[0]);
    cx = m_x + SPEED * (e - w);
    if (cx < 0 || cx > 16383) cx = m_x;
    nx = (grid[m_y / 256][cx / 256] == 3'd0) ? cx : m_x;
    cy = m_y + SPEED * (s - n);
    if (cy < 0 || cy > 8191) cy = m_y;
    ny = (grid[cy / 256][nx / 256] == 3'd0) ? cy : m_y;
    na = (m_a + 256 + TURN * (r - l)) % 256;
  endfunction

  task automatic set_keys(input logic [5:0] k);
    {key_north, key_south, key_east, key_west, key_turn_left, key_turn_right} = k;
  endtask

  task automatic clear_grid();
    for (int yy = 0; yy < 32; yy++)
      for (int xx = 0; xx < 64; xx++)
        grid[yy][xx] = 3'd0;
  endtask

  // Entered and left at a negedge. extra_k: cycle of a stray start (0 = none);
  // abort_at: cycle at which reset_player is pulsed (0 = none, 1..6).
  task automatic frame(input logic [5:0] k, input int extra_k, input int abort_at);
    int cx, cy, nx, ny, na, oy;
    exp_t e;
    oy = m_y;
    model(k, cx, cy, nx, ny, na);
    set_keys(k);
    start = 1'b1;
    if (abort_at == 0) begin
      e.x = nx; e.y = ny; e.a = na; e.edge_n = cyc + 1;
      sb.push_back(e);
    end
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      start        = (c == extra_k);
      reset_player = (c == abort_at);
      set_keys(6'($urandom()));
      if (abort_at != 0 && c > abort_at) begin
        chk("grid_x_aborted", int'(grid_x), 0);
        chk("grid_y_aborted", int'(grid_y), 0);
      end else if (c <= 3) begin
        chk("grid_x_xphase", int'(grid_x), cx / 256);
        chk("grid_y_xphase", int'(grid_y), oy / 256);
      end else if (c <= 6) begin
        chk("grid_x_yphase", int'(grid_x), nx / 256);
        chk("grid_y_yphase", int'(grid_y), cy / 256);
      end else begin
        chk("grid_x_done", int'(grid_x), 0);
        chk("grid_y_done", int'(grid_y), 0);
      end
    end
    @(negedge clock);
    start        = 1'b0;
    reset_player = 1'b0;
    if (abort_at != 0) begin
      m_x = SPAWN_X; m_y = SPAWN_Y; m_a = SPAWN_A;
    end else begin
      m_x = nx; m_y = ny; m_a = na;
    end
    chk("done_outstanding", sb.size(), 0);
  endtask

  task automatic spawn();
    reset_player = 1'b1;
    @(negedge clock);
    reset_player = 1'b0;
    m_x = SPAWN_X; m_y = SPAWN_Y; m_a = SPAWN_A;
  endtask

  task automatic chk_pos(input string tag, input int x, input int y, input int a);
    chk({tag, "_x"}, int'(player_x), x);
    chk({tag, "_y"}, int'(player_y), y);
    chk({tag, "_angle"}, int'(player_angle), a);
  endtask

  initial begin
    int ab, ex;
    clear_grid();
    m_x = 0; m_y = 0; m_a = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    chk_pos("reset", 0, 0, 0);
    chk("reset_done", int'(done), 0);
    chk("reset_grid_x", int'(grid_x), 0);
    chk("reset_grid_y", int'(grid_y), 0);

    // Lower boundary: west/north at coordinate 0 are rejected.
    frame(6'b100100, 0, 0);
    chk_pos("low_bound", 0, 0, 0);

    // Upper boundary: walk to the far corner; the last steps are rejected.
    for (int i = 0; i < 1024; i++) frame(6'b011000, 0, 0);
    chk_pos("high_bound", 16368, 8176, 0);

    spawn();
    chk_pos("spawn", 384, 384, 0);

    frame(6'b011000, 0, 0);
    chk_pos("free_move", 400, 400, 0);

    // Wall sliding: east into blocked cell (2,1), south still allowed.
    spawn();
    repeat (7) frame(6'b001000, 0, 0);
    chk_pos("approach", 496, 384, 0);
    grid[1][2] = 3'd3;
    frame(6'b011000, 0, 0);
    chk_pos("slide", 496, 400, 0);

    clear_grid();
    spawn();
    frame(6'b000010, 0, 0);
    chk_pos("angle_wrap", 384, 384, 254);
    frame(6'b001111, 0, 0);
    chk_pos("opposing", 384, 384, 254);

    frame(6'b011000, 2, 0);
    chk_pos("stray_start", 400, 400, 254);

    frame(6'b011000, 0, 4);
    chk_pos("abort", 384, 384, 0);
    frame(6'b001000, 0, 0);
    chk_pos("after_abort", 400, 384, 0);

    // reset_player wins over a simultaneous start.
    start = 1'b1;
    reset_player = 1'b1;
    @(negedge clock);
    start = 1'b0;
    reset_player = 1'b0;
    m_x = SPAWN_X; m_y = SPAWN_Y; m_a = SPAWN_A;
    repeat (10) @(negedge clock);
    chk_pos("start_vs_spawn", 384, 384, 0);

    // Randomized frames over a sparse random level.
    for (int yy = 0; yy < 32; yy++)
      for (int xx = 0; xx < 64; xx++)
        grid[yy][xx] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    grid[1][1] = 3'd0;
    spawn();
    for (int i = 0; i < 400; i++) begin
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 6)) : 0;
      ex = (ab == 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      frame(6'($urandom()), ex, ab);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    chk_pos("random_end", m_x, m_y, m_a);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
